// File: rtl/ay_bus_master.sv
// AY/YM PSG bus initiator: queues register commands and plays them out as BDIR/BC/data bus cycles.
// Define AY_BUS_READ_EN to build the read-cycle path (R_HOLD/R_GAP states, RD_VALID/RD_DATA).
module ay_bus_master #(
    parameter int HOLD_CYCLES     = 4,
    parameter int IDLE_CYCLES     = 4,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_CMD,
    input  logic [7:0] REQ_ADDR,
    input  logic [7:0] REQ_DATA,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] BUS_DO,
    input  logic [7:0] BUS_DI,
    output logic       RD_VALID,
    output logic [7:0] RD_DATA,
    output logic       BUSY
);
    // The receiver double-syncs and edge-detects BDIR, so an active phase shorter than 3 cycles is invisible.
    localparam int HOLD  = (HOLD_CYCLES < 3) ? 3 : HOLD_CYCLES;
    localparam int GAP   = (IDLE_CYCLES < 1) ? 1 : IDLE_CYCLES;
    localparam int CNT_W = $clog2((HOLD > GAP) ? HOLD : GAP) + 1;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [1:0] CMD_WRITE  = 2'b00;
    localparam logic [1:0] CMD_SELECT = 2'b01;
    localparam logic [1:0] CMD_RSVD   = 2'b11;
`ifdef AY_BUS_READ_EN
    localparam logic [1:0] CMD_READ   = 2'b10;
`endif

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_HOLD, A_GAP, D_SETUP, D_HOLD, D_GAP
`ifdef AY_BUS_READ_EN
        , R_HOLD, R_GAP
`endif
    } state_e;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   fcnt_t;
    typedef logic [CNT_W-1:0]           cnt_t;
    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    localparam cnt_t HOLD_LOAD = cnt_t'(HOLD - 1);
    localparam cnt_t GAP_LOAD  = cnt_t'(GAP - 1);

    entry_t     mem [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    fcnt_t      fcnt_q, fcnt_d;
    logic       ready_en_q;
    logic       fifo_empty, fifo_full, push, pop;
    entry_t     head;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] data_q, data_d;
    logic [7:0] bus_do_q, bus_do_d;
    logic       bdir_q, bdir_d, bc_q, bc_d;
    logic       done;

    assign fifo_empty = (fcnt_q == '0);
    assign fifo_full  = (fcnt_q == fcnt_t'(DEPTH));
    assign REQ_READY  = ready_en_q & ~fifo_full;
    assign push       = REQ_VALID & REQ_READY;
    assign head       = mem[rd_ptr_q];
    assign done       = (cnt_q == '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        fcnt_d   = fcnt_q + fcnt_t'(push) - fcnt_t'(pop);
    end

    // NOTE: the storage array carries no reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= {REQ_CMD, REQ_ADDR, REQ_DATA};
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = done ? cnt_q : cnt_q - cnt_t'(1);
        cmd_d    = cmd_q;
        data_d   = data_q;
        bus_do_d = bus_do_q;
        pop      = 1'b0;
        bdir_d   = 1'b0;
        bc_d     = 1'b0;

        unique case (state_q)
            IDLE: if (!fifo_empty) begin
                pop    = 1'b1;
                cmd_d  = head.cmd;
                data_d = head.data;
                if (head.cmd != CMD_RSVD) begin
                    state_d  = A_SETUP;
                    cnt_d    = '0;
                    bus_do_d = (head.cmd == CMD_SELECT) ? {5'b11111, head.addr[2:0]} : head.addr;
                end
            end
            A_SETUP: begin
                state_d = A_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            A_HOLD: if (done) begin
                state_d = A_GAP;
                cnt_d   = GAP_LOAD;
            end
            A_GAP: if (done) begin
                state_d = IDLE;
                if (cmd_q == CMD_WRITE) begin
                    state_d  = D_SETUP;
                    cnt_d    = '0;
                    bus_do_d = data_q;
                end
`ifdef AY_BUS_READ_EN
                else if (cmd_q == CMD_READ) begin
                    state_d = R_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
`endif
            end
            D_SETUP: begin
                state_d = D_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            D_HOLD: if (done) begin
                state_d = D_GAP;
                cnt_d   = GAP_LOAD;
            end
            D_GAP: if (done) state_d = IDLE;
`ifdef AY_BUS_READ_EN
            R_HOLD: if (done) begin
                state_d = R_GAP;
                cnt_d   = GAP_LOAD;
            end
            R_GAP: if (done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered alongside the state so they change cleanly on the same edge.
        case (state_d)
            A_HOLD: begin
                bdir_d = 1'b1;
                bc_d   = 1'b1;
            end
            D_HOLD: bdir_d = 1'b1;
`ifdef AY_BUS_READ_EN
            R_HOLD: bc_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_en_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            bus_do_q   <= '0;
            bdir_q     <= 1'b0;
            bc_q       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            bus_do_q   <= bus_do_d;
            bdir_q     <= bdir_d;
            bc_q       <= bc_d;
        end
    end

    assign BDIR   = bdir_q;
    assign BC     = bc_q;
    assign BUS_DO = bus_do_q;
    assign BUSY   = (state_q != IDLE) | ~fifo_empty;

`ifdef AY_BUS_READ_EN
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    // Chip data is taken on the last R_HOLD cycle, when it has had the whole phase to settle.
    always_comb begin
        rd_valid_d = (state_q == R_HOLD) && done;
        rd_data_d  = rd_valid_d ? BUS_DI : rd_data_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;
`else
    logic unused_bus_di;
    assign unused_bus_di = ^BUS_DI;
    assign RD_VALID      = 1'b0;
    assign RD_DATA       = 8'h00;
`endif
endmodule

// File: tb/tb_ay_bus_master.sv
// Self-checking bench for ay_bus_master: table-driven single commands plus hand-written queueing,
// reset-abort and clamped-HOLD sequences; a small PSG receiver model observes the bus.
module tb_ay_bus_master;
`ifdef AY_BUS_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       req_valid, req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_addr, req_data;
    logic       bdir, bc, rd_valid, busy;
    logic [7:0] bus_do, bus_di, rd_data;

    logic       h1_valid, h1_ready, h1_bdir, h1_bc, h1_rd_valid, h1_busy;
    logic [1:0] h1_cmd;
    logic [7:0] h1_addr, h1_data, h1_bus_do, h1_bus_di, h1_rd_data;

    always #5 CLK = ~CLK;

    ay_bus_master u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_CMD(req_cmd),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .BDIR(bdir), .BC(bc), .BUS_DO(bus_do), .BUS_DI(bus_di),
        .RD_VALID(rd_valid), .RD_DATA(rd_data), .BUSY(busy)
    );

    ay_bus_master #(.HOLD_CYCLES(1)) u_dut_h1 (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(h1_valid), .REQ_READY(h1_ready), .REQ_CMD(h1_cmd),
        .REQ_ADDR(h1_addr), .REQ_DATA(h1_data),
        .BDIR(h1_bdir), .BC(h1_bc), .BUS_DO(h1_bus_do), .BUS_DI(h1_bus_di),
        .RD_VALID(h1_rd_valid), .RD_DATA(h1_rd_data), .BUSY(h1_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: latches the register number on BDIR/BC=11, writes it on 10; logs each BDIR rise.
    logic [7:0] model_regs [16];
    logic [7:0] model_addr;
    logic [8:0] ev_q [$];
    logic       prev_bdir;

    always @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_bdir <= 1'b0;
        end else begin
            prev_bdir <= bdir;
            if (bdir && !prev_bdir) ev_q.push_back({bc, bus_do});
            if (bdir && bc)  model_addr <= bus_do;
            if (bdir && !bc) model_regs[model_addr[3:0]] <= bus_do;
        end
    end

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] di;
        logic [7:0] exp_abyte;
        int         exp_len;
        bit         has_data;
        bit         has_read;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    // Expected {BDIR, BC, BUS_DO} on cycle t after the pop, for HOLD=4, IDLE=4.
    function automatic logic [9:0] exp_bus(input vec_t v, input int t);
        int a_end;
        a_end = 1 + 4 + 4;
        if (t == 0)    return {2'b00, v.exp_abyte};
        if (t <= 4)    return {2'b11, v.exp_abyte};
        if (t < a_end) return {2'b00, v.exp_abyte};
        if (v.has_data) begin
            if (t == a_end)     return {2'b00, v.data};
            if (t <= a_end + 4) return {2'b10, v.data};
            return {2'b00, v.data};
        end
        if (v.has_read && t < a_end + 4) return {2'b01, v.exp_abyte};
        return {2'b00, v.exp_abyte};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_rd;
        int         acc_cyc [10];
        int         idx, cyc, waited;
        logic       ready_s, stall_seen, busy_seen;
        int         n_busy, a_len, d_len;

        vecs[0] = '{2'b00, 8'h07, 8'h38, 8'h00, 8'h07, 18, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 8'h06, 8'h55, 8'h00, 8'hFE, 9, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 8'h0E, 8'h00, 8'hA5, 8'h0E, RD_EN ? 17 : 9, 1'b0, RD_EN};
        vecs[3] = '{2'b01, 8'h3A, 8'h00, 8'h00, 8'hFA, 9, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 18, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 8'h03, 8'h00, 8'h5C, 8'h03, RD_EN ? 17 : 9, 1'b0, RD_EN};
        last_rd = 8'h00;

        RESET_N   = 1'b0;
        req_valid = 1'b0; req_cmd = 2'b00; req_addr = 8'h00; req_data = 8'h00; bus_di = 8'h00;
        h1_valid  = 1'b0; h1_cmd = 2'b00; h1_addr = 8'h00; h1_data = 8'h00; h1_bus_di = 8'h00;

        // Reset state and first-edge READY.
        @(negedge CLK);
        @(negedge CLK);
        check("reset outputs", 64'({bdir, bc, bus_do, rd_valid, rd_data, busy, req_ready}), 64'(0));
        RESET_N = 1'b1;
        #1;
        check("ready before first edge", 64'(req_ready), 64'(0));
        @(negedge CLK);
        check("ready after first edge", 64'(req_ready), 64'(1));

        // Table-driven single commands.
        for (int i = 0; i < NV; i++) begin
            vec_t       v;
            logic [9:0] act, ex, fa, fe;
            int         mism, pulses, pulse_t, exp_pt;
            logic       busy_last, busy_after;
            v = vecs[i];
            mism = 0; pulses = 0; pulse_t = -1; busy_last = 1'b0;
            fa = '0; fe = '0;

            req_cmd = v.cmd; req_addr = v.addr; req_data = v.data; bus_di = v.di;
            req_valid = 1'b1;
            @(negedge CLK);
            req_valid = 1'b0;
            check($sformatf("row%0d busy while queued", i), 64'(busy), 64'(1));

            for (int t = 0; t < v.exp_len; t++) begin
                @(negedge CLK);
                act = {bdir, bc, bus_do};
                ex  = exp_bus(v, t);
                if (act !== ex && mism == 0) begin fa = act; fe = ex; end
                if (act !== ex) mism++;
                if (mism == 0) begin fa = act; fe = ex; end
                if (rd_valid) begin pulses++; pulse_t = t; end
                busy_last = busy;
            end
            @(negedge CLK);
            busy_after = busy;
            if (rd_valid) pulses++;

            check($sformatf("row%0d bus trace", i), 64'(fa), 64'(fe));
            check($sformatf("row%0d busy length", i), 64'({busy_last, busy_after}), 64'(2'b10));
            exp_pt = v.has_read ? 13 : -1;
            check($sformatf("row%0d rd_valid pulse", i), 64'({pulses, pulse_t}),
                  64'({int'(v.has_read), exp_pt}));
            if (v.has_read) last_rd = v.di;
            check($sformatf("row%0d rd_data", i), 64'(rd_data), 64'(last_rd));
            if (v.cmd == 2'b00)
                check($sformatf("row%0d model reg", i), 64'(model_regs[v.addr[3:0]]), 64'(v.data));
            else
                check($sformatf("row%0d model addr", i), 64'(model_addr), 64'(v.exp_abyte));
        end

        // Reserved command between two writes: dropped silently, one IDLE cycle for the drop.
        ev_q.delete();
        cyc = 0;
        req_cmd = 2'b00; req_addr = 8'h01; req_data = 8'h11; req_valid = 1'b1;
        @(negedge CLK); cyc++;
        req_cmd = 2'b11; req_addr = 8'h77; req_data = 8'h77;
        @(negedge CLK); cyc++;
        req_cmd = 2'b00; req_addr = 8'h02; req_data = 8'h22;
        @(negedge CLK); cyc++;
        req_valid = 1'b0;
        while (busy && cyc < 200) begin
            @(negedge CLK); cyc++;
        end
        check("rsvd busy end edge", 64'(cyc), 64'(40));
        check("rsvd event count", 64'(ev_q.size()), 64'(4));
        check("rsvd event order", 64'({ev_q[0], ev_q[1], ev_q[2], ev_q[3]}),
              64'({1'b1, 8'h01, 1'b0, 8'h11, 1'b1, 8'h02, 1'b0, 8'h22}));

        // Ten back-to-back writes with REQ_VALID held.
        ev_q.delete();
        idx = 0; cyc = 0; stall_seen = 1'b0;
        foreach (acc_cyc[k]) acc_cyc[k] = -1;
        req_cmd = 2'b00; req_addr = 8'h10; req_data = 8'h80; req_valid = 1'b1;
        while (idx < 10 && cyc < 100) begin
            ready_s = req_ready;
            if (idx == 9 && !ready_s) stall_seen = 1'b1;
            @(negedge CLK); cyc++;
            if (ready_s) begin
                acc_cyc[idx] = cyc;
                idx++;
                req_addr = 8'h10 + 8'(idx);
                req_data = 8'h80 + 8'(idx);
            end
        end
        req_valid = 1'b0;
        check("b2b ready low for 10th", 64'(stall_seen), 64'(1));
        check("b2b accept edges 9th/10th", 64'({acc_cyc[8], acc_cyc[9]}), 64'({32'd9, 32'd22}));
        waited = 0;
        while (busy && waited < 400) begin
            @(negedge CLK); waited++;
        end
        check("b2b drained", 64'(busy), 64'(0));
        check("b2b event count", 64'(ev_q.size()), 64'(20));
        begin
            logic [8:0] fa9, fe9;
            fa9 = '0; fe9 = '0;
            for (int k = 0; k < 20; k++) begin
                logic [8:0] e;
                e = (k % 2 == 0) ? {1'b1, 8'h10 + 8'(k / 2)} : {1'b0, 8'h80 + 8'(k / 2)};
                if (k < ev_q.size()) begin
                    if (fa9 === fe9) begin fa9 = ev_q[k]; fe9 = e; end
                end
            end
            check("b2b bus order", 64'(fa9), 64'(fe9));
        end

        // HOLD_CYCLES=1 clamps to 3-cycle active phases.
        h1_cmd = 2'b00; h1_addr = 8'h05; h1_data = 8'hAA; h1_valid = 1'b1;
        @(negedge CLK);
        h1_valid = 1'b0;
        n_busy = 0; a_len = 0; d_len = 0;
        for (int t = 0; t < 60; t++) begin
            if (h1_busy) n_busy++;
            if (h1_bdir && h1_bc)  a_len++;
            if (h1_bdir && !h1_bc) d_len++;
            @(negedge CLK);
        end
        check("h1 address phase length", 64'(a_len), 64'(3));
        check("h1 data phase length", 64'(d_len), 64'(3));
        check("h1 busy cycles", 64'(n_busy), 64'(17));

        // Reset asserted mid D_HOLD with a second write still queued.
        req_cmd = 2'b00; req_addr = 8'h09; req_data = 8'h5A; req_valid = 1'b1;
        @(negedge CLK);
        req_addr = 8'h0A; req_data = 8'h11;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (11) @(negedge CLK);
        check("pre-reset in D_HOLD", 64'({bdir, bc, bus_do}), 64'({2'b10, 8'h5A}));
        #2;
        RESET_N = 1'b0;
        #1;
        check("async reset outputs", 64'({bdir, bc, bus_do, busy, req_ready, rd_valid, rd_data}), 64'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("post-reset ready before edge", 64'(req_ready), 64'(0));
        @(negedge CLK);
        check("post-reset first edge", 64'({req_ready, busy, bdir, bc}), 64'(4'b1000));
        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            busy_seen = busy_seen | busy | bdir | bc;
        end
        check("fifo flushed by reset", 64'(busy_seen), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
